// File: rtl/regex_pkg.sv
// ---------------------------------------------------------------------------
// regex_pkg
//   Shared definitions for the regex checker input path.
//   - state_e    : character reader FSM encoding (IDLE=0, EMIT=1)
//   - WIDTH_DEF  : default fifo word width
//   - CHAR_W_DEF : default character width
//   - NUL        : the NUL character value
//   - idx_bits() : slot index width for a given chars-per-word count (min 1)
// ---------------------------------------------------------------------------
package regex_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   localparam int WIDTH_DEF  = 16;
   localparam int CHAR_W_DEF = 8;

   localparam logic [CHAR_W_DEF-1:0] NUL = '0;

   // A single-char word still needs a 1-bit index register.
   function automatic int idx_bits(input int chars);
      return (chars > 1) ? $clog2(chars) : 1;
   endfunction

endpackage

// File: rtl/fifo_char_reader_char_sel.sv
// ---------------------------------------------------------------------------
// char_sel
//   Combinational slot mux: picks character idx_i out of the held word,
//   slot 0 being the most significant character.
//   Ports:
//     hold_i  in  WIDTH   held fifo word
//     idx_i   in  IDX_W   slot index (0 = MSB char)
//     nul_o   out 1       selected slot is NUL (only with REGEX_SKIP_NUL_EN)
//     char_o  out CHAR_W  selected character
//   Configuration macro: REGEX_SKIP_NUL_EN adds the NUL detect output.
// ---------------------------------------------------------------------------
module char_sel
   import regex_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int CHAR_W = CHAR_W_DEF,
   parameter int CHARS  = WIDTH / CHAR_W,
   parameter int IDX_W  = idx_bits(CHARS)
) (
   input  logic [WIDTH-1:0]  hold_i,
   input  logic [IDX_W-1:0]  idx_i,
`ifdef REGEX_SKIP_NUL_EN
   output logic              nul_o,
`endif
   output logic [CHAR_W-1:0] char_o
);

   // Slot view of the word, reordered so slot[0] is the first char sent.
   logic [CHARS-1:0][CHAR_W-1:0] slot;

   for (genvar c = 0; c < CHARS; c++) begin : g_slot
      assign slot[c] = hold_i[WIDTH-1-c*CHAR_W -: CHAR_W];
   end

   // Compare-based mux keeps non-power-of-two CHARS free of
   // out-of-range array reads.
   always_comb begin
      char_o = '0;
      for (int c = 0; c < CHARS; c++) begin
         if (idx_i == IDX_W'(c)) char_o = slot[c];
      end
   end

`ifdef REGEX_SKIP_NUL_EN
   assign nul_o = (char_o == CHAR_W'(NUL));
`endif

endmodule

// File: rtl/fifo_char_reader.sv
// ---------------------------------------------------------------------------
// fifo_char_reader
//   Read side of the regex checker input fifo. Pops WIDTH-bit words from a
//   first-word-fall-through fifo and serializes them, MSB char first, into
//   CHAR_W-bit characters on a valid/ready stream.
//   Ports:
//     clk             in   1       clock, posedge
//     res             in   1       asynchronous active-high reset
//     en              in   1       allow new pops (current word always completes)
//     fifo_empty      in   1       fifo empty flag
//     fifo_data_out   in   WIDTH   fifo head word (valid while !fifo_empty)
//     fifo_shift_out  out  1       pop strobe, head dropped at posedge
//     char_valid      out  1       char_data holds a character
//     char_ready      in   1       downstream accepts
//     char_data       out  CHAR_W  current character
//     word_done       out  1       pulse after the last slot of a word retires
//     busy            out  1       a word is held (EMIT)
//   Configuration macro: REGEX_SKIP_NUL_EN -- NUL slots are not presented;
//   each one spends one cycle with char_valid=0 and retires like a transfer.
// ---------------------------------------------------------------------------
module fifo_char_reader
   import regex_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int CHAR_W = CHAR_W_DEF
) (
   input  logic              clk,
   input  logic              res,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic [WIDTH-1:0]  fifo_data_out,
   output logic              fifo_shift_out,
   output logic              char_valid,
   input  logic              char_ready,
   output logic [CHAR_W-1:0] char_data,
   output logic              word_done,
   output logic              busy
);

   // WIDTH must be a multiple of CHAR_W; CHARS >= 1.
   localparam int CHARS = WIDTH / CHAR_W;
   localparam int IDX_W = idx_bits(CHARS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARS - 1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  hold_q,  hold_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic              done_q,  done_d;
   logic              pop;
   logic              skip;

   // -------------------------------------------------------------------------
   // Slot select
   // -------------------------------------------------------------------------
`ifdef REGEX_SKIP_NUL_EN
   logic slot_nul;
   assign skip = slot_nul;
`else
   assign skip = 1'b0;
`endif

   char_sel #(
      .WIDTH  (WIDTH),
      .CHAR_W (CHAR_W),
      .CHARS  (CHARS),
      .IDX_W  (IDX_W)
   ) u_char_sel (
      .hold_i (hold_q),
      .idx_i  (idx_q),
`ifdef REGEX_SKIP_NUL_EN
      .nul_o  (slot_nul),
`endif
      .char_o (char_data)
   );

   // -------------------------------------------------------------------------
   // FSM next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      idx_d      = idx_q;
      done_d     = 1'b0;
      pop        = 1'b0;
      char_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            pop = en & ~fifo_empty;
         end
         EMIT: begin
            char_valid = ~skip;
            // A skipped NUL slot retires exactly like an accepted char.
            if (skip | char_ready) begin
               if (idx_q == LAST_IDX) begin
                  done_d = 1'b1;
                  // Pop the next word in the retiring cycle so a busy
                  // fifo streams without a bubble.
                  pop    = en & ~fifo_empty;
                  if (!pop) state_d = IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         hold_d  = fifo_data_out;
         idx_d   = '0;
         state_d = EMIT;
      end
   end

   // Reset holds the FSM in IDLE where pop could otherwise follow en/empty.
   assign fifo_shift_out = pop & ~res;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign word_done = done_q;
   assign busy      = (state_q == EMIT);

endmodule

// File: tb/tb_fifo_char_reader.sv
module tb_fifo_char_reader;

   localparam int WIDTH  = 16;
   localparam int CHAR_W = 8;
   localparam int CHARS  = WIDTH / CHAR_W;

   logic              clk = 1'b0;
   logic              res = 1'b0;
   logic              en = 1'b0;
   logic              fifo_empty;
   logic [WIDTH-1:0]  fifo_data_out;
   logic              fifo_shift_out;
   logic              char_valid;
   logic              char_ready = 1'b0;
   logic [CHAR_W-1:0] char_data;
   logic              word_done;
   logic              busy;

   always #5 clk = ~clk;

   fifo_char_reader #(.WIDTH(WIDTH), .CHAR_W(CHAR_W)) dut (
      .clk            (clk),
      .res            (res),
      .en             (en),
      .fifo_empty     (fifo_empty),
      .fifo_data_out  (fifo_data_out),
      .fifo_shift_out (fifo_shift_out),
      .char_valid     (char_valid),
      .char_ready     (char_ready),
      .char_data      (char_data),
      .word_done      (word_done),
      .busy           (busy)
   );

   // FWFT fifo model: writes from the stimulus process, pops on posedge.
   logic [WIDTH-1:0] mem [0:31];
   int wr_ptr  = 0;
   int rd_ptr  = 0;
   int pop_cnt = 0;

   assign fifo_empty    = (rd_ptr == wr_ptr);
   assign fifo_data_out = mem[rd_ptr[4:0]];

   always @(posedge clk) begin
      if (fifo_shift_out && !fifo_empty) begin
         rd_ptr  <= rd_ptr + 1;
         pop_cnt <= pop_cnt + 1;
      end
   end

   // Scoreboard and counters
   logic [CHAR_W-1:0] exp_q[$];
   int checks  = 0;
   int errors  = 0;
   int wd_cnt  = 0;
   int xfer_cnt = 0;

   task automatic push_word(input logic [WIDTH-1:0] w);
      logic [CHAR_W-1:0] ch;
      mem[wr_ptr[4:0]] = w;
      wr_ptr++;
      for (int c = 0; c < CHARS; c++) begin
         ch = w[WIDTH-1-c*CHAR_W -: CHAR_W];
`ifdef REGEX_SKIP_NUL_EN
         if (ch != '0) exp_q.push_back(ch);
`else
         exp_q.push_back(ch);
`endif
      end
   endtask

   // One clock cycle: sample at negedge (scoreboard pop on transfer),
   // return 1 time unit after the next posedge, ready for new drive.
   task automatic cyc();
      logic [CHAR_W-1:0] e;
      @(negedge clk);
      if (!res) begin
         checks++;
         if (fifo_shift_out && fifo_empty) begin
            errors++;
            $display("FAIL pop_while_empty: shift_out=%b empty=%b required shift_out=0", fifo_shift_out, fifo_empty);
         end
         if (word_done) wd_cnt++;
         if (char_valid && char_ready) begin
            xfer_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra_char: got %h, no char expected", char_data);
            end else begin
               e = exp_q.pop_front();
               if (char_data !== e) begin
                  errors++;
                  $display("FAIL sb_char: got %h expected %h", char_data, e);
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         cyc();
         n++;
      end
      repeat (4) cyc();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!char_valid && n < 20) begin
         cyc();
         n++;
      end
      checks++;
      if (char_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: char_valid=%b after %0d cycles, required 1", name, char_valid, n);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      #1 res = 1'b1;
      en = 1'b1;
      char_ready = 1'b0;
      push_word(16'h4142);   // fifo non-empty during reset: no pop allowed
      #2;
      checks++;
      if ({char_valid, word_done, busy, fifo_shift_out} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: valid/done/busy/shift=%b required 0000",
                  {char_valid, word_done, busy, fifo_shift_out});
      end
      checks++;
      if (char_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %h required 00", char_data);
      end
      @(posedge clk); #1;
      checks++;
      if (pop_cnt !== 0) begin
         errors++;
         $display("FAIL reset_no_pop: pops=%0d required 0", pop_cnt);
      end
      res = 1'b0;
   endtask

   task automatic test_single();
      int p0 = pop_cnt, w0 = wd_cnt, x0 = xfer_cnt;
      char_ready = 1'b1;
      wait_valid("single");
      cyc();
      cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_consecutive: %0d chars left after 2 cycles, required 0", exp_q.size());
      end
      repeat (3) cyc();
      checks++;
      if (pop_cnt - p0 != 1 || wd_cnt - w0 != 1 || xfer_cnt - x0 != 2) begin
         errors++;
         $display("FAIL single_counts: pops=%0d done=%0d xfers=%0d required 1 1 2",
                  pop_cnt - p0, wd_cnt - w0, xfer_cnt - x0);
      end
   endtask

   task automatic test_back_to_back();
      int p0 = pop_cnt, w0 = wd_cnt, bubbles = 0;
      en = 1'b0;
      for (int i = 1; i <= 8; i++) push_word(WIDTH'(i));
      char_ready = 1'b1;
      en = 1'b1;
      wait_valid("b2b");
      for (int i = 0; i < 16; i++) begin
         if (!char_valid) bubbles++;
         cyc();
      end
      checks++;
      if (bubbles != 0) begin
         errors++;
         $display("FAIL b2b_bubble: %0d invalid cycles in 16-char burst, required 0", bubbles);
      end
      drain(10);
      checks++;
      if (pop_cnt - p0 != 8 || wd_cnt - w0 != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_counts: pops=%0d done=%0d left=%0d required 8 8 0",
                  pop_cnt - p0, wd_cnt - w0, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int w0 = wd_cnt;
      char_ready = 1'b0;
      push_word(16'hA5C3);
      checks++;
      if (char_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_latency_early: valid=%b in pop cycle, required 0", char_valid);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (char_valid !== 1'b1 || char_data !== 8'hA5) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d valid=%b data=%h required 1 a5", i, char_valid, char_data);
         end
      end
      char_ready = 1'b1;
      cyc();
      cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_release: %0d chars left, required 0", exp_q.size());
      end
      repeat (3) cyc();
      checks++;
      if (wd_cnt - w0 != 1) begin
         errors++;
         $display("FAIL bp_done: pulses=%0d required 1", wd_cnt - w0);
      end
   endtask

   task automatic test_enable();
      int p0, w0;
      en = 1'b0;
      char_ready = 1'b1;
      push_word(16'h1234);
      push_word(16'h5678);
      p0 = pop_cnt;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (char_valid !== 1'b0 || fifo_shift_out !== 1'b0) begin
            errors++;
            $display("FAIL en_halt: valid=%b shift=%b required 0 0", char_valid, fifo_shift_out);
         end
         cyc();
      end
      w0 = wd_cnt;
      char_ready = 1'b0;
      en = 1'b1;
      cyc();
      en = 1'b0;
      repeat (2) cyc();
      char_ready = 1'b1;
      repeat (6) cyc();
      checks++;
      if (pop_cnt - p0 != 1 || wd_cnt - w0 != 1 || exp_q.size() != 2) begin
         errors++;
         $display("FAIL en_one_word: pops=%0d done=%0d left=%0d required 1 1 2",
                  pop_cnt - p0, wd_cnt - w0, exp_q.size());
      end
      checks++;
      if (char_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL en_idle: valid=%b busy=%b required 0 0", char_valid, busy);
      end
      en = 1'b1;
      drain(10);
      checks++;
      if (pop_cnt - p0 != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL en_resume: pops=%0d left=%0d required 2 0", pop_cnt - p0, exp_q.size());
      end
   endtask

   task automatic test_reset_midword();
      int p0, w0;
      en = 1'b1;
      char_ready = 1'b0;
      push_word(16'h1122);
      wait_valid("rst_mid");
      checks++;
      if (char_data !== 8'h11) begin
         errors++;
         $display("FAIL rst_mid_pending: got %h required 11", char_data);
      end
      #2 res = 1'b1;
      #1;
      checks++;
      if ({char_valid, busy, word_done, fifo_shift_out} !== 4'b0000 || char_data !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_async: valid/busy/done/shift=%b data=%h required 0000 00",
                  {char_valid, busy, word_done, fifo_shift_out}, char_data);
      end
      exp_q.delete();   // held word is discarded
      cyc();
      res = 1'b0;
      p0 = pop_cnt;
      w0 = wd_cnt;
      char_ready = 1'b1;
      push_word(16'h3344);
      drain(10);
      checks++;
      if (pop_cnt - p0 != 1 || wd_cnt - w0 != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rst_mid_next: pops=%0d done=%0d left=%0d required 1 1 0",
                  pop_cnt - p0, wd_cnt - w0, exp_q.size());
      end
   endtask

   task automatic test_nul();
      int p0 = pop_cnt, w0 = wd_cnt, x0 = xfer_cnt;
`ifdef REGEX_SKIP_NUL_EN
      int xfers_req = 2;
`else
      int xfers_req = 6;
`endif
      en = 1'b1;
      char_ready = 1'b1;
      push_word(16'h0041);
      push_word(16'h0000);
      push_word(16'h4200);
      drain(20);
      repeat (4) cyc();
      checks++;
      if (pop_cnt - p0 != 3 || wd_cnt - w0 != 3) begin
         errors++;
         $display("FAIL nul_words: pops=%0d done=%0d required 3 3", pop_cnt - p0, wd_cnt - w0);
      end
      checks++;
      if (xfer_cnt - x0 != xfers_req || exp_q.size() != 0) begin
         errors++;
         $display("FAIL nul_chars: xfers=%0d left=%0d required %0d 0",
                  xfer_cnt - x0, exp_q.size(), xfers_req);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_enable();
      test_reset_midword();
      test_nul();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
